// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-word RAM port between the icache and the dcache.
// The dcache has priority. A grant is held until its access completes (ramstate == ACCESS).
// A starvation counter forces an icache grant after STARVE_LIMIT back-to-back
// dcache completions while the icache is waiting.
//
// Handshake: a cache raises its request and holds the address/data stable.
// It keeps them until its wait output is 0 for one cycle, and that cycle is the completion.
// Arbitration uses the live requests in that completion cycle.
// A requester that still holds its request can therefore be granted again with no gap.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t           state, state_nxt, arb_st;
    logic [CNT_W-1:0] count, count_nxt;
    logic             ireq, dreq, access, i_done, d_done;

    assign ireq      = iREN;
    assign dreq      = dREN | dWEN;
    assign access    = (ramstate == RS_ACCESS);
    assign i_done    = (state == IGNT) && ireq && access;
    assign d_done    = (state == DGNT) && dreq && access;
    assign state_dbg = state;

    // Starve count: counts dcache completions while the icache keeps asking; saturates.
    always_comb begin
        count_nxt = count;
        if (!iREN || i_done) begin
            count_nxt = '0;
        end else if (d_done && (count != CNT_MAX)) begin
            count_nxt = count + 1'b1;
        end
    end

    // Priority pick; uses the updated count so the limit-th dcache completion hands over.
    always_comb begin
        arb_st = IDLE;
        if (dreq && ireq && (count_nxt == CNT_MAX)) begin
            arb_st = IGNT;
        end else if (dreq) begin
            arb_st = DGNT;
        end else if (ireq) begin
            arb_st = IGNT;
        end
    end

    // Next state: re-arbitrate when idle, on completion, or when the owner withdraws.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arb_st;
            IGNT:    if (!ireq || access) state_nxt = arb_st;
            DGNT:    if (!dreq || access) state_nxt = arb_st;
            default: state_nxt = IDLE;
        endcase
    end

    // State and starve count registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // RAM side and cache wait signals, decoded from the grant and the live requests.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = ~i_done;
        dwait    = ~d_done;
        iload    = ramload;
        dload    = ramload;
        case (state)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A table of per-cycle vectors is applied first.
// Hand-written sequences then cover reset with requests pending and reset during an access.
module tb_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
    localparam logic [1:0] S_IDLE = 2'd0, S_IGNT = 2'd1, S_DGNT = 2'd2;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .state_dbg(state_dbg)
    );

    // clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic        i_ren, d_ren, d_wen;
        logic [31:0] ia, da, ds, rl;
        logic [1:0]  rs;
        logic [1:0]  e_st;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_iw, e_dw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string tag, logic i_ren, logic d_ren, logic d_wen,
                                logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                                logic [31:0] rl, logic [1:0] rs, logic [1:0] e_st,
                                logic e_ren, logic e_wen, logic [31:0] e_addr,
                                logic [31:0] e_store, logic e_iw, logic e_dw);
        vec_t v;
        v.tag = tag; v.i_ren = i_ren; v.d_ren = d_ren; v.d_wen = d_wen;
        v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
        v.e_st = e_st; v.e_ren = e_ren; v.e_wen = e_wen;
        v.e_addr = e_addr; v.e_store = e_store; v.e_iw = e_iw; v.e_dw = e_dw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic i_ren, input logic d_ren, input logic d_wen,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input logic [31:0] rl, input logic [1:0] rs);
        iREN = i_ren; dREN = d_ren; dWEN = d_wen;
        iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    endtask

    // called at posedge+1; samples mid-cycle, then moves to the next posedge+1
    task automatic apply(input vec_t v);
        drive(v.i_ren, v.d_ren, v.d_wen, v.ia, v.da, v.ds, v.rl, v.rs);
        #3;
        chk({v.tag, ".state"},    32'(state_dbg), 32'(v.e_st));
        chk({v.tag, ".ramREN"},   32'(ramREN),    32'(v.e_ren));
        chk({v.tag, ".ramWEN"},   32'(ramWEN),    32'(v.e_wen));
        chk({v.tag, ".ramaddr"},  ramaddr,        v.e_addr);
        chk({v.tag, ".ramstore"}, ramstore,       v.e_store);
        chk({v.tag, ".iwait"},    32'(iwait),     32'(v.e_iw));
        chk({v.tag, ".dwait"},    32'(dwait),     32'(v.e_dw));
        chk({v.tag, ".iload"},    iload,          v.rl);
        chk({v.tag, ".dload"},    dload,          v.rl);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // ---- reset with iREN and dWEN both asserted ----
        nRST = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h20, 32'h99, 32'h0, FREE);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.state",  32'(state_dbg), 32'(S_IDLE));
        chk("rst.ramREN", 32'(ramREN), 32'd0);
        chk("rst.ramWEN", 32'(ramWEN), 32'd0);
        chk("rst.iwait",  32'(iwait), 32'd1);
        chk("rst.dwait",  32'(dwait), 32'd1);
        nRST = 1'b1;
        #3;
        chk("rel.state", 32'(state_dbg), 32'(S_IDLE));
        @(posedge CLK);
        #1;
        #3;
        chk("first.state",  32'(state_dbg), 32'(S_DGNT));
        chk("first.ramWEN", 32'(ramWEN), 32'd1);
        chk("first.ramREN", 32'(ramREN), 32'd0);
        chk("first.addr",   ramaddr, 32'h20);
        // drop everything: the withdrawn grant returns to IDLE
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
        @(posedge CLK);
        #1;

        // ---- vector table ----
        // icache read with three BUSY cycles
        vecs.push_back(mk("i_req",   1,0,0, 32'h40,0,0,0, FREE,   S_IDLE,0,0,0,0,1,1));
        vecs.push_back(mk("i_busy1", 1,0,0, 32'h40,0,0,0, BUSY,   S_IGNT,1,0,32'h40,0,1,1));
        vecs.push_back(mk("i_busy2", 1,0,0, 32'h40,0,0,0, BUSY,   S_IGNT,1,0,32'h40,0,1,1));
        vecs.push_back(mk("i_busy3", 1,0,0, 32'h40,0,0,0, BUSY,   S_IGNT,1,0,32'h40,0,1,1));
        vecs.push_back(mk("i_acc",   1,0,0, 32'h40,0,0,32'hDEADBEEF, ACC, S_IGNT,1,0,32'h40,0,0,1));
        vecs.push_back(mk("i_drop",  0,0,0, 0,0,0,0, FREE,        S_IGNT,0,0,0,0,1,1));
        // dcache write with dREN and dWEN both set
        vecs.push_back(mk("w_req",   0,1,1, 0,32'h80,32'h1234,0, FREE, S_IDLE,0,0,0,0,1,1));
        vecs.push_back(mk("w_acc",   0,1,1, 0,32'h80,32'h1234,0, ACC,  S_DGNT,0,1,32'h80,32'h1234,1,0));
        vecs.push_back(mk("w_drop",  0,0,0, 0,0,0,0, FREE,        S_DGNT,0,0,0,0,1,1));
        // simultaneous requests: dcache first, then icache without passing through IDLE
        vecs.push_back(mk("both_req", 1,1,0, 32'h200,32'h100,0,0, FREE, S_IDLE,0,0,0,0,1,1));
        vecs.push_back(mk("both_dacc",1,1,0, 32'h200,32'h100,0,32'h11111111, ACC, S_DGNT,1,0,32'h100,0,1,0));
        vecs.push_back(mk("both_dwd", 1,0,0, 32'h200,0,0,0, FREE, S_DGNT,0,0,0,0,1,1));
        vecs.push_back(mk("both_iacc",1,0,0, 32'h200,0,0,32'h22222222, ACC, S_IGNT,1,0,32'h200,0,0,1));
        vecs.push_back(mk("both_drop",0,0,0, 0,0,0,0, FREE, S_IGNT,0,0,0,0,1,1));
        // starvation guard: 4 dcache writes, 1 icache read, dcache resumes
        vecs.push_back(mk("st_req",  1,0,1, 32'h400,32'h300,32'hA5A5A5A5,0, FREE, S_IDLE,0,0,0,0,1,1));
        for (int k = 1; k <= 4; k++)
            vecs.push_back(mk($sformatf("st_d%0d", k), 1,0,1, 32'h400,32'h300,32'hA5A5A5A5,0, ACC,
                              S_DGNT,0,1,32'h300,32'hA5A5A5A5,1,0));
        vecs.push_back(mk("st_i",    1,0,1, 32'h400,32'h300,32'hA5A5A5A5,32'h33333333, ACC,
                          S_IGNT,1,0,32'h400,0,0,1));
        vecs.push_back(mk("st_dres", 0,0,1, 0,32'h300,32'hA5A5A5A5,0, ACC,
                          S_DGNT,0,1,32'h300,32'hA5A5A5A5,1,0));
        vecs.push_back(mk("st_drop", 0,0,0, 0,0,0,0, FREE, S_DGNT,0,0,0,0,1,1));
        vecs.push_back(mk("st_idle", 0,0,0, 0,0,0,0, FREE, S_IDLE,0,0,0,0,1,1));
        // ERROR holds the grant with wait high and RAM still driven
        vecs.push_back(mk("e_req",   0,1,0, 0,32'h500,0,0, FREE, S_IDLE,0,0,0,0,1,1));
        vecs.push_back(mk("e_err1",  0,1,0, 0,32'h500,0,0, ERR,  S_DGNT,1,0,32'h500,0,1,1));
        vecs.push_back(mk("e_err2",  0,1,0, 0,32'h500,0,0, ERR,  S_DGNT,1,0,32'h500,0,1,1));
        vecs.push_back(mk("e_acc",   0,1,0, 0,32'h500,0,32'h44444444, ACC, S_DGNT,1,0,32'h500,0,1,0));
        vecs.push_back(mk("e_drop",  0,0,0, 0,0,0,0, FREE, S_DGNT,0,0,0,0,1,1));
        vecs.push_back(mk("e_idle",  0,0,0, 0,0,0,0, FREE, S_IDLE,0,0,0,0,1,1));

        foreach (vecs[n]) apply(vecs[n]);

        // ---- nRST pulsed during a BUSY dcache write ----
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h600, 32'h77, 32'h0, FREE);
        @(posedge CLK);
        #1;
        ramstate = BUSY;
        #2;
        chk("mr.pre_state",  32'(state_dbg), 32'(S_DGNT));
        chk("mr.pre_ramWEN", 32'(ramWEN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("mr.state",    32'(state_dbg), 32'(S_IDLE));
        chk("mr.ramWEN",   32'(ramWEN), 32'd0);
        chk("mr.ramstore", ramstore, 32'h0);
        chk("mr.dwait",    32'(dwait), 32'd1);
        ramstate = ACC;
        #1;
        chk("mr.acc_dwait", 32'(dwait), 32'd1);
        @(posedge CLK);
        #1;
        chk("mr.held_state", 32'(state_dbg), 32'(S_IDLE));
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        #3;
        chk("mr.regrant_state", 32'(state_dbg), 32'(S_DGNT));
        chk("mr.regrant_dwait", 32'(dwait), 32'd0);
        chk("mr.regrant_addr",  ramaddr, 32'h600);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
        repeat (2) @(posedge CLK);
        #1;
        chk("mr.end_state", 32'(state_dbg), 32'(S_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
